// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, PC source select and fetch FSM state encoding.
// Also holds the branch-offset helper used by next-PC calculation.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT   = 32;

    // Branch offsets are word counts: sign-extend, then scale to bytes.
    function automatic word_t br_offset(input logic [15:0] imm16);
        br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, branch, jump and jump-register.
// Also flags a JR target that is not word aligned.
module pc_next_calc
    import cpu_types_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
    input  word_t        pc_out,
    input  logic [1:0]   pc_src,
    input  logic         branch_taken,
    input  logic [15:0]  imm16,
    input  logic [25:0]  jaddr26,
    input  word_t        jr_target,
    output word_t        pc_in,
    output logic         jr_misalign
);

    word_t npc_s;

    // Select the next PC; all arithmetic is 32-bit modulo.
    always_comb begin
        npc_s       = pc_out + word_t'(PC_STEP);
        pc_in       = npc_s;
        jr_misalign = 1'b0;
        case (pcsrc_t'(pc_src))
            SEQ: pc_in = npc_s;
            BR: begin
                if (branch_taken) begin
                    pc_in = npc_s + br_offset(imm16);
                end else begin
                    pc_in = npc_s;
                end
            end
            J:   pc_in = {npc_s[31:28], jaddr26, 2'b00};
            JR: begin
                pc_in       = {jr_target[31:2], 2'b00};
                jr_misalign = (jr_target[1:0] != 2'b00);
            end
            default: pc_in = npc_s;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: fetches at pc_out, holds the instruction while it
// executes, and commits the next PC exactly once per retired instruction.
module pc_fetch_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  word_t             pc_out,
    output word_t             pc_in,
    output logic              pcWEN,
    output logic              imemREN,
    output word_t             imemaddr,
    input  logic              ihit,
    input  word_t             imemload,
    output word_t             instr,
    output logic              instr_valid,
    input  logic [1:0]        pc_src,
    input  logic              branch_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jaddr26,
    input  word_t             jr_target,
    input  logic              dstall,
    input  logic              halt,
    output logic              halted,
    output logic              misalign,
    output logic [CNT_W-1:0]  retired
);

    fetch_state_t       state_r;
    word_t              instr_r;
    logic               imemren_r;
    logic               ivalid_r;
    logic               halted_r;
    logic               misalign_r;
    logic [CNT_W-1:0]   retired_r;
    logic               commit_s;
    logic               jr_misalign_s;
    word_t              pc_next_s;

    pc_next_calc #(
        .PC_STEP (PC_STEP)
    ) u_pc_next_calc (
        .pc_out       (pc_out),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jaddr26      (jaddr26),
        .jr_target    (jr_target),
        .pc_in        (pc_next_s),
        .jr_misalign  (jr_misalign_s)
    );

    // Commit is the only combinational control output: it must pulse in the EXEC cycle itself.
    always_comb begin
        commit_s = 1'b0;
        if ((state_r == EXEC) && !dstall && !halt) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Fetch FSM with registered status outputs, instruction latch, sticky flags and retire counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= FETCH;
            instr_r    <= 32'h0000_0000;
            imemren_r  <= 1'b1;
            ivalid_r   <= 1'b0;
            halted_r   <= 1'b0;
            misalign_r <= 1'b0;
            retired_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                FETCH: begin
                    if (ihit) begin
                        instr_r   <= imemload;
                        state_r   <= EXEC;
                        imemren_r <= 1'b0;
                        ivalid_r  <= 1'b1;
                    end
                end
                EXEC: begin
                    // dstall outranks halt so an outstanding data access completes first.
                    if (dstall) begin
                        state_r <= EXEC;
                    end else if (halt) begin
                        state_r   <= HALT;
                        ivalid_r  <= 1'b0;
                        halted_r  <= 1'b1;
                        imemren_r <= 1'b0;
                    end else begin
                        state_r   <= FETCH;
                        ivalid_r  <= 1'b0;
                        imemren_r <= 1'b1;
                        retired_r <= retired_r + CNT_W'(1);
                        if (jr_misalign_s) begin
                            misalign_r <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_r   <= HALT;
                    imemren_r <= 1'b0;
                    ivalid_r  <= 1'b0;
                    halted_r  <= 1'b1;
                end
                default: begin
                    state_r   <= FETCH;
                    imemren_r <= 1'b1;
                    ivalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_in       = pc_next_s;
    assign pcWEN       = commit_s;
    assign imemaddr    = pc_out;
    assign imemREN     = imemren_r;
    assign instr       = instr_r;
    assign instr_valid = ivalid_r;
    assign halted      = halted_r;
    assign misalign    = misalign_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl: next-PC selection, stalls,
// halt, PC wrap and reset while an instruction is executing.
module tb_pc_fetch_ctrl;
    import cpu_types_pkg::*;

    logic         CLK;
    logic         nRST;
    word_t        pc_out;
    word_t        pc_in;
    logic         pcWEN;
    logic         imemREN;
    word_t        imemaddr;
    logic         ihit;
    word_t        imemload;
    word_t        instr;
    logic         instr_valid;
    logic [1:0]   pc_src;
    logic         branch_taken;
    logic [15:0]  imm16;
    logic [25:0]  jaddr26;
    word_t        jr_target;
    logic         dstall;
    logic         halt;
    logic         halted;
    logic         misalign;
    logic [31:0]  retired;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    pc_fetch_ctrl #(.PC_STEP(4), .CNT_W(32)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc_out       (pc_out),
        .pc_in        (pc_in),
        .pcWEN        (pcWEN),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .ihit         (ihit),
        .imemload     (imemload),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jaddr26      (jaddr26),
        .jr_target    (jr_target),
        .dstall       (dstall),
        .halt         (halt),
        .halted       (halted),
        .misalign     (misalign),
        .retired      (retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One fetch (ihit on first FETCH cycle) plus an unstalled commit.
    task automatic run_instr(input string tag, input logic [1:0] src, input logic tk,
                             input logic [15:0] imm, input logic [25:0] ja, input word_t jr,
                             input word_t pc, input word_t ld, input word_t exp_pc);
        pc_out = pc; pc_src = src; branch_taken = tk; imm16 = imm;
        jaddr26 = ja; jr_target = jr; imemload = ld; ihit = 1'b1;
        tick();
        ihit = 1'b0;
        chk_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk_eq({tag, "_instr"}, instr, ld);
        chk_eq({tag, "_wen"},   32'(pcWEN), 32'd1);
        chk_eq({tag, "_pcin"},  pc_in, exp_pc);
        tick();
        exp_ret++;
        chk_eq({tag, "_ret"},    retired, 32'(exp_ret));
        chk_eq({tag, "_wen_lo"}, 32'(pcWEN), 32'd0);
        chk_eq({tag, "_ren"},    32'(imemREN), 32'd1);
    endtask

    initial begin
        nRST = 1'b0; pc_out = 32'h0; ihit = 1'b0; imemload = 32'h0;
        pc_src = 2'(SEQ); branch_taken = 1'b0; imm16 = 16'h0; jaddr26 = 26'h0;
        jr_target = 32'h0; dstall = 1'b0; halt = 1'b0;
        tick(); tick();
        chk_eq("rst_instr",  instr, 32'h0);
        chk_eq("rst_wen",    32'(pcWEN), 32'd0);
        chk_eq("rst_valid",  32'(instr_valid), 32'd0);
        chk_eq("rst_halted", 32'(halted), 32'd0);
        chk_eq("rst_mis",    32'(misalign), 32'd0);
        chk_eq("rst_ret",    retired, 32'd0);
        chk_eq("rst_ren",    32'(imemREN), 32'd1);
        nRST = 1'b1;
        tick();
        chk_eq("fetch_wait_ren", 32'(imemREN), 32'd1);
        chk_eq("fetch_wait_wen", 32'(pcWEN), 32'd0);

        run_instr("seq",   2'(SEQ), 1'b0, 16'h0,    26'h0,  32'h0,   32'h0000_0000, 32'h2000_0001, 32'h0000_0004);
        run_instr("br_t",  2'(BR),  1'b1, 16'hFFFE, 26'h0,  32'h0,   32'h0000_0100, 32'h1000_0002, 32'h0000_00FC);
        run_instr("br_nt", 2'(BR),  1'b0, 16'hFFFE, 26'h0,  32'h0,   32'h0000_0100, 32'h1000_0003, 32'h0000_0104);
        run_instr("jmp",   2'(J),   1'b0, 16'h0,    26'h40, 32'h0,   32'hF000_0010, 32'h0800_0040, 32'hF000_0100);
        run_instr("wrap",  2'(SEQ), 1'b0, 16'h0,    26'h0,  32'h0,   32'hFFFF_FFFC, 32'h0000_0020, 32'h0000_0000);
        chk_eq("pre_jr_mis", 32'(misalign), 32'd0);
        run_instr("jr",    2'(JR),  1'b0, 16'h0,    26'h0,  32'h203, 32'h0000_0200, 32'h0060_0008, 32'h0000_0200);
        chk_eq("jr_mis", 32'(misalign), 32'd1);

        // ihit delayed three cycles, then two dstall cycles in EXEC.
        pc_out = 32'h40; pc_src = 2'(SEQ); imemload = 32'hAAAA_5555; ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("iwait_ren",   32'(imemREN), 32'd1);
            chk_eq("iwait_valid", 32'(instr_valid), 32'd0);
        end
        ihit = 1'b1; dstall = 1'b1;
        tick();
        imemload = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            chk_eq("dstall_wen",   32'(pcWEN), 32'd0);
            chk_eq("dstall_valid", 32'(instr_valid), 32'd1);
            tick();
        end
        ihit = 1'b0;
        chk_eq("exec_ihit_ignored", instr, 32'hAAAA_5555);
        dstall = 1'b0;
        #1;
        chk_eq("stall_release_wen",  32'(pcWEN), 32'd1);
        chk_eq("stall_release_pcin", pc_in, 32'h0000_0044);
        tick();
        exp_ret++;
        chk_eq("stall_ret",    retired, 32'(exp_ret));
        chk_eq("stall_wen_lo", 32'(pcWEN), 32'd0);

        // Halt with dstall: no commit, HALT once dstall drops.
        pc_out = 32'h80; ihit = 1'b1; halt = 1'b1; dstall = 1'b1;
        tick();
        ihit = 1'b0;
        chk_eq("halt_stall_wen",   32'(pcWEN), 32'd0);
        chk_eq("halt_stall_valid", 32'(instr_valid), 32'd1);
        dstall = 1'b0;
        #1;
        chk_eq("halt_wen", 32'(pcWEN), 32'd0);
        tick();
        chk_eq("halt_halted", 32'(halted), 32'd1);
        chk_eq("halt_ren",    32'(imemREN), 32'd0);
        chk_eq("halt_valid",  32'(instr_valid), 32'd0);
        halt = 1'b0; ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("halt_stay", 32'(halted), 32'd1);
            chk_eq("halt_ren2", 32'(imemREN), 32'd0);
            chk_eq("halt_wen2", 32'(pcWEN), 32'd0);
        end
        chk_eq("halt_ret", retired, 32'(exp_ret));
        ihit = 1'b0;

        // Reset asserted while an instruction sits in EXEC.
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        exp_ret = 0;
        pc_out = 32'h10; pc_src = 2'(SEQ); imemload = 32'hDEAD_BEEF; ihit = 1'b1;
        tick();
        ihit = 1'b0;
        chk_eq("rexec_wen_pre", 32'(pcWEN), 32'd1);
        nRST = 1'b0;
        #1;
        chk_eq("rexec_wen",    32'(pcWEN), 32'd0);
        chk_eq("rexec_valid",  32'(instr_valid), 32'd0);
        chk_eq("rexec_instr",  instr, 32'h0);
        chk_eq("rexec_ret",    retired, 32'd0);
        chk_eq("rexec_mis",    32'(misalign), 32'd0);
        chk_eq("rexec_halted", 32'(halted), 32'd0);
        chk_eq("rexec_ren",    32'(imemREN), 32'd1);
        tick();
        nRST = 1'b1;
        tick();
        chk_eq("rexec_ret_after", retired, 32'(exp_ret));
        chk_eq("rexec_addr",      imemaddr, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
